// File: rtl/stall_ctrl.sv
// rtl/stall_ctrl.sv - pipeline stall vector, wrong-path fetch drop, stall counters and watchdog

// Saturating event counter with synchronous clear; clear wins over increment.
module stall_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count qualifying cycles, sticking at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

module stall_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_stall_req,
  input  logic             id_stall_req,
  input  logic             mem_stall_req,
  input  logic             jump_flag,
  input  logic             clr_cnt_i,
  output logic [4:0]       stall_signal,
  output logic             drop_fetch_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_if,
  output logic [CNT_W-1:0] stall_cnt_id,
  output logic [CNT_W-1:0] stall_cnt_mem,
  output logic [CNT_W-1:0] jump_cnt
);

  localparam int RUN_W = $clog2(TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(TIMEOUT);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TIMEOUT - 1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             jump_acc;
  logic             stalled;
  logic             win_if;
  logic             win_id;
  logic             win_mem;
  logic [RUN_W-1:0] run_len;

  // A jump is only taken once EX is free to move, i.e. MEM is not holding it.
  assign jump_acc = jump_flag && !mem_stall_req;

  // Fixed-priority stall vector: the deepest requesting stage freezes everything behind it.
  always_comb begin
    stall_signal = 5'b00000;
    if (mem_stall_req) begin
      stall_signal = 5'b11111;
    end else if (id_stall_req) begin
      stall_signal = 5'b00111;
    end else if (if_stall_req) begin
      stall_signal = 5'b00011;
    end
  end

  assign stalled = |stall_signal;

  // Exactly one cause is credited per stalled cycle: the one that won the priority.
  assign win_mem = mem_stall_req;
  assign win_id  = id_stall_req && !mem_stall_req;
  assign win_if  = if_stall_req && !id_stall_req && !mem_stall_req;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: enter DRAIN when a jump lands on an in-flight fetch, leave once that fetch returns.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (jump_acc && if_stall_req) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (jump_acc) begin
          state_nxt = ST_DRAIN;
        end else if (!if_stall_req) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Moore output: the word returning while in DRAIN belongs to the abandoned path.
  always_comb begin
    drop_fetch_o = 1'b0;
    if (state == ST_DRAIN) begin
      drop_fetch_o = 1'b1;
    end
  end

  // Length of the current run of stalled cycles, capped at the trip point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_len <= '0;
    end else if (clr_cnt_i || !stalled) begin
      run_len <= '0;
    end else if (run_len != RUN_MAX) begin
      run_len <= run_len + 1'b1;
    end
  end

  // Sticky watchdog flag, set on the edge that completes TIMEOUT consecutive stalled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_o <= 1'b0;
    end else if (clr_cnt_i) begin
      timeout_o <= 1'b0;
    end else if (stalled && (run_len == RUN_LAST)) begin
      timeout_o <= 1'b1;
    end
  end

  stall_sat_cnt #(.W(CNT_W)) u_cnt_if (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt_i),
    .inc (win_if),
    .cnt (stall_cnt_if)
  );

  stall_sat_cnt #(.W(CNT_W)) u_cnt_id (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt_i),
    .inc (win_id),
    .cnt (stall_cnt_id)
  );

  stall_sat_cnt #(.W(CNT_W)) u_cnt_mem (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt_i),
    .inc (win_mem),
    .cnt (stall_cnt_mem)
  );

  stall_sat_cnt #(.W(CNT_W)) u_cnt_jump (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt_i),
    .inc (jump_acc),
    .cnt (jump_cnt)
  );

endmodule
